// File: rtl/vae_pkg.sv
// Shared types, constants and helpers for the VAE reparameterization sampler.
// Holds the exp() std table generator, LFSR polynomial, FSM states and saturation.
package vae_pkg;

    localparam int LFSR_W = 24;
    // Right-shifting Galois mask for x^24 + x^23 + x^22 + x^17 + 1.
    localparam logic [LFSR_W-1:0] LFSR_POLY = 24'hE10000;

    localparam int STD_W = 10;
    localparam int LUT_N = 64;

    typedef logic [LUT_N-1:0][STD_W-1:0] std_lut_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Entry idx holds round(exp((idx-32)/16) * 2^frac). Evaluated only at elaboration:
    // a Taylor series in Q40 fixed point, accurate far below the final rounding step.
    function automatic std_lut_t build_std_lut(input int frac);
        std_lut_t lut;
        longint   acc;
        longint   term;
        longint   x_num;
        lut = '0;
        for (int idx = 0; idx < LUT_N; idx++) begin
            x_num = longint'(idx) - 64'sd32;
            term  = 64'sd1 <<< 40;
            acc   = term;
            for (longint n = 1; n < 40; n++) begin
                term = (term * x_num) / (64'sd16 * n);
                acc  = acc + term;
            end
            acc = (acc + (64'sd1 <<< (39 - frac))) >>> (40 - frac);
            lut[idx] = STD_W'(acc);
        end
        return lut;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/vae_reparam_sampler_gauss_lfsr.sv
// Approximate Gaussian noise source: 24-bit Galois LFSR whose four 6-bit fields
// are summed as signed values; the output is forced to zero when not advancing.
module gauss_lfsr
    import vae_pkg::*;
#(
    parameter logic [LFSR_W-1:0] seed = 24'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic signed [7:0] eps
);

    localparam logic [LFSR_W-1:0] SEED_NZ = (seed == '0) ? LFSR_W'(1) : seed;

    logic [LFSR_W-1:0] state;
    logic [7:0]        sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_NZ;
        end else if (adv) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_POLY : '0);
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        sum = '0;
        for (int f = 0; f < 4; f++) begin
            sum = sum + {{2{state[6*f+5]}}, state[6*f +: 6]};
        end
        eps = adv ? $signed(sum) : 8'sd0;
    end

endmodule

// File: rtl/vae_reparam_sampler.sv
// Reparameterization stage: snapshots mu/logvar on a start edge, then produces
// z[k] = sat(mu + exp(logvar/2) * eps) one element per cycle through a 2-stage pipe.
module vae_reparam_sampler
    import vae_pkg::*;
#(
    parameter int                latent_number = 10,
    parameter int                width         = 11,
    parameter int                frac          = 6,
    parameter logic [LFSR_W-1:0] seed          = 24'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    noise_en,
    input  logic signed [width-1:0] mu     [0:latent_number-1],
    input  logic signed [width-1:0] logvar [0:latent_number-1],
    output logic signed [width-1:0] z      [0:latent_number-1],
    output logic                    busy,
    output logic                    done
);

    localparam int       IDX_W   = (latent_number > 1) ? $clog2(latent_number) : 1;
    localparam int       T_W     = width + 9;
    localparam std_lut_t STD_LUT = build_std_lut(frac);

    state_t state;
    state_t next_state;
    logic   start_q;
    logic   trigger;
    logic   issue;
    logic   last_issue;

    logic [IDX_W-1:0]        k;
    logic signed [width-1:0] mu_s [0:latent_number-1];
    logic signed [width-1:0] lv_s [0:latent_number-1];

    logic signed [width-1:0] lv_shift;
    logic [5:0]              lut_idx;
    logic signed [7:0]       eps;

    logic                    s2_valid;
    logic [IDX_W-1:0]        s2_idx;
    logic [STD_W-1:0]        s2_std;
    logic signed [7:0]       s2_eps;
    logic signed [width-1:0] s2_mu;

    logic signed [18:0]      prod;
    logic signed [T_W-1:0]   t_sum;
    logic signed [width-1:0] z_val;

    assign trigger    = start & ~start_q & (state == IDLE);
    assign issue      = (state == RUN);
    assign last_issue = issue && (k == IDX_W'(latent_number - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = RUN;
            RUN:     if (last_issue) next_state = DRAIN;
            DRAIN:   if (!s2_valid) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            k        <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
        end else begin
            state    <= next_state;
            start_q  <= start;
            busy     <= (next_state != IDLE);
            done     <= (next_state == DONE);
            s2_valid <= issue;
            s2_idx   <= k;
            if (trigger || last_issue) begin
                k <= '0;
            end else if (issue) begin
                k <= k + IDX_W'(1);
            end
        end
    end

    // NOTE: snapshot and pipeline data registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (trigger) begin
            mu_s <= mu;
            lv_s <= logvar;
        end
        s2_std <= STD_LUT[lut_idx];
        s2_eps <= eps;
        s2_mu  <= mu_s[k];
    end

    always_comb begin
        lv_shift = lv_s[k] >>> (frac - 3);
        if (lv_shift < -32) begin
            lut_idx = 6'd0;
        end else if (lv_shift > 31) begin
            lut_idx = 6'd63;
        end else begin
            lut_idx = 6'(lv_shift + 32);
        end
    end

    gauss_lfsr #(
        .seed (seed)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (issue & noise_en),
        .eps   (eps)
    );

    // The shift by 5 drops eps's fractional bits, leaving std's frac scaling.
    always_comb begin
        prod  = 19'($signed({1'b0, s2_std})) * 19'(s2_eps);
        t_sum = T_W'(prod >>> 5) + T_W'(s2_mu);
        z_val = width'(sat(longint'(t_sum), width));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < latent_number; j++) begin
                z[j] <= '0;
            end
        end else if (s2_valid) begin
            z[s2_idx] <= z_val;
        end
    end

endmodule

// File: tb/tb_vae_reparam_sampler.sv
// Self-checking bench for vae_reparam_sampler: directed steps with random data,
// compared against a real-arithmetic reference model of the reparameterization.
module tb_vae_reparam_sampler;

    localparam int          L    = 10;
    localparam int          W    = 11;
    localparam logic [23:0] SEED = 24'hACE1;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic start    = 1'b0;
    logic noise_en = 1'b0;
    logic signed [W-1:0] mu     [0:L-1];
    logic signed [W-1:0] logvar [0:L-1];
    logic signed [W-1:0] z      [0:L-1];
    logic busy;
    logic done;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [23:0] m_lfsr    = SEED;
    int          exp_z [0:L-1];

    vae_reparam_sampler #(
        .latent_number (L),
        .width         (W),
        .frac          (6),
        .seed          (SEED)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .noise_en (noise_en),
        .mu       (mu),
        .logvar   (logvar),
        .z        (z),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int field_sum(input logic [23:0] s);
        int e;
        int v;
        e = 0;
        for (int f = 0; f < 4; f++) begin
            v = int'((s >> (6 * f)) & 24'h3F);
            if (v >= 32) v = v - 64;
            e = e + v;
        end
        return e;
    endfunction

    // Expected z[] for one run of the current inputs; advances the model noise source.
    task automatic model_run();
        int  i;
        int  sd;
        int  e;
        int  t;
        for (int k = 0; k < L; k++) begin
            i = $rtoi($floor(real'(logvar[k]) / 8.0));
            if (i < -32) i = -32;
            if (i > 31) i = 31;
            sd = $rtoi($floor($exp(real'(i) / 16.0) * 64.0 + 0.5));
            e  = 0;
            if (noise_en) begin
                e      = field_sum(m_lfsr);
                m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 24'hE10000) : (m_lfsr >> 1);
            end
            t = $rtoi($floor(real'(sd * e) / 32.0)) + int'(mu[k]);
            if (t > 1023) t = 1023;
            if (t < -1024) t = -1024;
            exp_z[k] = t;
        end
    endtask

    task automatic check_z(input string tag);
        for (int k = 0; k < L; k++) begin
            check($sformatf("%s z[%0d]", tag, k), 32'(z[k]), exp_z[k]);
        end
    endtask

    // One triggered run: optional held start, a second mid-run edge, and mu changed after trigger.
    task automatic do_run(input string tag, input bit hold, input int glitch_c, input bit scramble);
        int done_cnt;
        int done_at;
        int busy_cnt;
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        model_run();
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (busy === 1'b1) busy_cnt++;
            if (c == 0 && !hold) start = 1'b0;
            if (c == 0 && scramble) begin
                for (int k = 0; k < L; k++) mu[k] = W'($urandom);
            end
            if (c == glitch_c) start = 1'b1;
        end
        start = 1'b0;
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " done cycle"}, done_at, L + 2);
        check({tag, " busy cycles"}, busy_cnt, L + 3);
        check_z(tag);
    endtask

    initial begin
        int done_cnt;
        for (int k = 0; k < L; k++) begin
            mu[k]     = '0;
            logvar[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle busy", 32'(busy), 0);
            check("idle done", 32'(done), 0);
            for (int k = 0; k < L; k++) check("idle z", 32'(z[k]), 0);
        end

        noise_en = 1'b0;
        for (int k = 0; k < L; k++) begin
            mu[k]     = W'(10 * k - 40);
            logvar[k] = W'($urandom);
        end
        do_run("deterministic", 1'b0, -1, 1'b0);

        noise_en = 1'b1;
        for (int k = 0; k < L; k++) begin
            mu[k]     = '0;
            logvar[k] = '0;
        end
        do_run("noise run1", 1'b0, -1, 1'b0);
        do_run("noise run2", 1'b0, -1, 1'b0);

        for (int k = 0; k < L; k++) begin
            mu[k]     = W'($urandom);
            logvar[k] = W'($urandom);
        end
        do_run("random", 1'b0, -1, 1'b0);

        for (int k = 0; k < L; k++) begin
            mu[k]     = '0;
            logvar[k] = -11'sd1024;
        end
        do_run("lut low clamp", 1'b0, -1, 1'b0);
        for (int k = 0; k < L; k++) logvar[k] = 11'sd1023;
        do_run("lut high clamp", 1'b0, -1, 1'b0);

        for (int k = 0; k < L; k++) mu[k] = (k % 2 == 0) ? 11'sd1000 : -11'sd1000;
        do_run("saturation", 1'b0, -1, 1'b0);

        for (int k = 0; k < L; k++) begin
            mu[k]     = W'($urandom);
            logvar[k] = W'($urandom_range(0, 255));
        end
        do_run("start held", 1'b1, -1, 1'b0);
        do_run("mid-run edge", 1'b0, 4, 1'b1);

        noise_en = 1'b1;
        for (int k = 0; k < L; k++) begin
            mu[k]     = '0;
            logvar[k] = '0;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < L; k++) check("reset abort z", 32'(z[k]), 0);
        check("reset abort busy", 32'(busy), 0);
        check("reset abort done", 32'(done), 0);
        m_lfsr = SEED;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("reset abort no done", done_cnt, 0);
        do_run("after reset", 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
